// File: rtl/ours_axi_mem_pkg.sv
// Shared constants, read-FSM encoding and info-bus width helpers for the
// terminating AXI memory responder.
package ours_axi_mem_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    localparam int         RESP_W      = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } rd_state_e;

    function automatic int addr_info_w(input int id_w, input int addr_w);
        return id_w + addr_w;
    endfunction

    function automatic int w_info_w(input int data_w);
        return data_w / 8 + data_w;
    endfunction

    function automatic int b_info_w(input int id_w);
        return id_w + RESP_W;
    endfunction

    function automatic int r_info_w(input int id_w, input int data_w);
        return id_w + RESP_W + data_w;
    endfunction

endpackage

// File: rtl/ours_axi_mem_bank.sv
// DEPTH x DATA_W memory, one byte-enabled write port and one registered read port.
// Each byte lane is its own array so every lane maps onto a plain block RAM.
module ours_axi_mem_bank
    import ours_axi_mem_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 256,
    localparam int IDX_W = $clog2(DEPTH),
    localparam int LANES = DATA_W / 8
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [LANES-1:0]  wr_strb,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_data
);

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];
            logic [7:0] rd_lane_reg;

            // Read captures the pre-write contents when both ports hit one word.
            always_ff @(posedge clk) begin
                if (wr_en && wr_strb[gi]) begin
                    lane_mem[wr_idx] <= wr_data[gi*8 +: 8];
                end
                if (rd_en) begin
                    rd_lane_reg <= lane_mem[rd_idx];
                end
            end

            assign rd_data[gi*8 +: 8] = rd_lane_reg;
        end
    endgenerate

endmodule

// File: rtl/ours_axi_mem_responder.sv
// Terminating single-beat AXI responder: holds AW/W until both are present,
// commits to the bank, and serves one read at a time with RD_LATENCY cycles.
module ours_axi_mem_responder
    import ours_axi_mem_pkg::*;
#(
    parameter int ID_W       = 4,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 64,
    parameter int DEPTH      = 256,
    parameter int RD_LATENCY = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 slave_aw_valid,
    input  logic [addr_info_w(ID_W, ADDR_W)-1:0] slave_aw_info,
    output logic                                 slave_aw_ready,
    input  logic                                 slave_w_valid,
    input  logic [w_info_w(DATA_W)-1:0]          slave_w_info,
    output logic                                 slave_w_ready,
    output logic                                 slave_b_valid,
    output logic [b_info_w(ID_W)-1:0]            slave_b_info,
    input  logic                                 slave_b_ready,
    input  logic                                 slave_ar_valid,
    input  logic [addr_info_w(ID_W, ADDR_W)-1:0] slave_ar_info,
    output logic                                 slave_ar_ready,
    output logic                                 slave_r_valid,
    output logic [r_info_w(ID_W, DATA_W)-1:0]    slave_r_info,
    input  logic                                 slave_r_ready
);

    localparam int STRB_W = DATA_W / 8;
    localparam int OFS    = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(DEPTH);
    localparam logic [ADDR_W:0] MEM_BYTES = (ADDR_W + 1)'(DEPTH * STRB_W);
    localparam logic [3:0]      CNT_INIT  = 4'(RD_LATENCY - 1);

    // Write-side holding registers and B channel
    logic              aw_held_reg, w_held_reg, b_valid_reg;
    logic [ID_W-1:0]   aw_id_reg;
    logic [ADDR_W-1:0] aw_addr_reg;
    logic [STRB_W-1:0] w_strb_reg;
    logic [DATA_W-1:0] w_data_reg;
    logic [ID_W+1:0]   b_info_reg;
    logic              commit, aw_in_range;

    assign aw_in_range = {1'b0, aw_addr_reg} < MEM_BYTES;
    assign commit      = aw_held_reg && w_held_reg && !b_valid_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            aw_held_reg <= 1'b0;
            w_held_reg  <= 1'b0;
            b_valid_reg <= 1'b0;
            b_info_reg  <= '0;
            aw_id_reg   <= '0;
            aw_addr_reg <= '0;
            w_strb_reg  <= '0;
            w_data_reg  <= '0;
        end else begin
            if (commit) begin
                aw_held_reg <= 1'b0;
                w_held_reg  <= 1'b0;
                b_valid_reg <= 1'b1;
                b_info_reg  <= {aw_id_reg, aw_in_range ? RESP_OKAY : RESP_DECERR};
            end else begin
                if (slave_aw_valid && !aw_held_reg) begin
                    aw_held_reg <= 1'b1;
                    aw_id_reg   <= slave_aw_info[ADDR_W +: ID_W];
                    aw_addr_reg <= slave_aw_info[ADDR_W-1:0];
                end
                if (slave_w_valid && !w_held_reg) begin
                    w_held_reg <= 1'b1;
                    w_strb_reg <= slave_w_info[DATA_W +: STRB_W];
                    w_data_reg <= slave_w_info[DATA_W-1:0];
                end
                if (b_valid_reg && slave_b_ready) begin
                    b_valid_reg <= 1'b0;
                end
            end
        end
    end

    assign slave_aw_ready = !aw_held_reg && !rst;
    assign slave_w_ready  = !w_held_reg && !rst;
    assign slave_b_valid  = b_valid_reg;
    assign slave_b_info   = b_info_reg;

    // Read FSM
    rd_state_e         state_reg;
    logic [3:0]        cnt_reg;
    logic [ID_W-1:0]   ar_id_reg, r_id_reg;
    logic [ADDR_W-1:0] ar_addr_reg;
    logic              r_valid_reg, r_ok_reg;
    logic [1:0]        r_resp_reg;
    logic [ADDR_W-1:0] ar_addr, rd_addr;
    logic [ID_W-1:0]   rd_id;
    logic              ar_hs, rd_load, rd_in_range;
    logic [DATA_W-1:0] rd_data;

    assign ar_addr     = slave_ar_info[ADDR_W-1:0];
    assign ar_hs       = slave_ar_valid && slave_ar_ready;
    // The load edge is the handshake edge itself when RD_LATENCY is 1
    assign rd_load     = (ar_hs && RD_LATENCY == 1) || (state_reg == WAIT && cnt_reg == 4'd1);
    assign rd_addr     = (state_reg == IDLE) ? ar_addr : ar_addr_reg;
    assign rd_id       = (state_reg == IDLE) ? slave_ar_info[ADDR_W +: ID_W] : ar_id_reg;
    assign rd_in_range = {1'b0, rd_addr} < MEM_BYTES;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            ar_id_reg   <= '0;
            ar_addr_reg <= '0;
            r_valid_reg <= 1'b0;
            r_ok_reg    <= 1'b0;
            r_id_reg    <= '0;
            r_resp_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (ar_hs) begin
                        ar_id_reg   <= slave_ar_info[ADDR_W +: ID_W];
                        ar_addr_reg <= ar_addr;
                        cnt_reg     <= CNT_INIT;
                        state_reg   <= (RD_LATENCY == 1) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    cnt_reg <= cnt_reg - 4'd1;
                    if (cnt_reg == 4'd1) begin
                        state_reg <= RESP;
                    end
                end
                RESP: begin
                    if (slave_r_ready) begin
                        state_reg   <= IDLE;
                        r_valid_reg <= 1'b0;
                        r_ok_reg    <= 1'b0;
                    end
                end
                default: state_reg <= IDLE;
            endcase
            if (rd_load) begin
                r_valid_reg <= 1'b1;
                r_ok_reg    <= rd_in_range;
                r_id_reg    <= rd_id;
                r_resp_reg  <= rd_in_range ? RESP_OKAY : RESP_DECERR;
            end
        end
    end

    assign slave_ar_ready = (state_reg == IDLE) && !rst;
    assign slave_r_valid  = r_valid_reg;
    assign slave_r_info   = {r_id_reg, r_resp_reg, (r_valid_reg && r_ok_reg) ? rd_data : '0};

    ours_axi_mem_bank #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH)
    ) u_bank (
        .clk    (clk),
        .wr_en  (commit && aw_in_range && !rst),
        .wr_idx (aw_addr_reg[OFS +: IDX_W]),
        .wr_strb(w_strb_reg),
        .wr_data(w_data_reg),
        .rd_en  (rd_load && !rst),
        .rd_idx (rd_addr[OFS +: IDX_W]),
        .rd_data(rd_data)
    );

    // Sub-word address bits carry no meaning for aligned accesses
    logic unused_addr_bits;
    assign unused_addr_bits = ^{aw_addr_reg[OFS-1:0], ar_addr_reg[OFS-1:0]};

endmodule

// File: tb/tb_ours_axi_mem_responder.sv
// Drives two responders (RD_LATENCY 2 and 1) with identical traffic and checks
// both against an array model of the memory and the response rules.
module tb_ours_axi_mem_responder;

    localparam int MEM_WORDS = 256;
    localparam int MEM_BYTES = MEM_WORDS * 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        aw_valid, w_valid, b_ready, ar_valid, r_ready;
    logic [35:0] aw_info, ar_info;
    logic [71:0] w_info;
    logic        aw_ready0, w_ready0, b_valid0, ar_ready0, r_valid0;
    logic        aw_ready1, w_ready1, b_valid1, ar_ready1, r_valid1;
    logic [5:0]  b_info0, b_info1;
    logic [69:0] r_info0, r_info1;

    int tests = 0;
    int fails = 0;
    logic [63:0] ref_mem [MEM_WORDS];

    always #5 clk = ~clk;

    ours_axi_mem_responder #(.RD_LATENCY(2)) dut0 (
        .clk(clk), .rst(rst),
        .slave_aw_valid(aw_valid), .slave_aw_info(aw_info), .slave_aw_ready(aw_ready0),
        .slave_w_valid(w_valid), .slave_w_info(w_info), .slave_w_ready(w_ready0),
        .slave_b_valid(b_valid0), .slave_b_info(b_info0), .slave_b_ready(b_ready),
        .slave_ar_valid(ar_valid), .slave_ar_info(ar_info), .slave_ar_ready(ar_ready0),
        .slave_r_valid(r_valid0), .slave_r_info(r_info0), .slave_r_ready(r_ready)
    );

    ours_axi_mem_responder #(.RD_LATENCY(1)) dut1 (
        .clk(clk), .rst(rst),
        .slave_aw_valid(aw_valid), .slave_aw_info(aw_info), .slave_aw_ready(aw_ready1),
        .slave_w_valid(w_valid), .slave_w_info(w_info), .slave_w_ready(w_ready1),
        .slave_b_valid(b_valid1), .slave_b_info(b_info1), .slave_b_ready(b_ready),
        .slave_ar_valid(ar_valid), .slave_ar_info(ar_info), .slave_ar_ready(ar_ready1),
        .slave_r_valid(r_valid1), .slave_r_info(r_info1), .slave_r_ready(r_ready)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] model_resp(input logic [31:0] a);
        return (a >= MEM_BYTES) ? 2'b11 : 2'b00;
    endfunction

    function automatic logic [63:0] model_rdata(input logic [31:0] a);
        if (a >= MEM_BYTES) return 64'h0;
        return ref_mem[(a / 8) % MEM_WORDS];
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [7:0] strb, input logic [63:0] data);
        if (a < MEM_BYTES) begin
            for (int b = 0; b < 8; b++) begin
                if (strb[b]) ref_mem[(a / 8) % MEM_WORDS][b*8 +: 8] = data[b*8 +: 8];
            end
        end
    endtask

    // AW and W in the same cycle; B must appear exactly two cycles later.
    task automatic do_write(input logic [3:0] id, input logic [31:0] addr,
                            input logic [7:0] strb, input logic [63:0] data);
        aw_valid = 1'b1; aw_info = {id, addr};
        w_valid  = 1'b1; w_info  = {strb, data};
        check("wr_readies", {aw_ready0, w_ready0, aw_ready1, w_ready1}, 4'b1111);
        step();
        aw_valid = 1'b0; w_valid = 1'b0;
        check("b_early", {b_valid0, b_valid1}, 2'b00);
        step();
        check("b_valid", {b_valid0, b_valid1}, 2'b11);
        check("b_info0", b_info0, {id, model_resp(addr)});
        check("b_info1", b_info1, {id, model_resp(addr)});
        model_write(addr, strb, data);
        b_ready = 1'b1;
        step();
        b_ready = 1'b0;
        check("b_clear", {b_valid0, b_valid1}, 2'b00);
        $display("[TB] write id=%0d addr=%h strb=%h data=%h", id, addr, strb, data);
    endtask

    // dut1 answers one cycle after the AR handshake, dut0 two cycles after.
    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input int hold,
                           output logic [63:0] obs);
        logic [69:0] exp;
        exp = {id, model_resp(addr), model_rdata(addr)};
        ar_valid = 1'b1; ar_info = {id, addr};
        check("ar_ready", {ar_ready0, ar_ready1}, 2'b11);
        step();
        ar_valid = 1'b0;
        check("r_lat1", {r_valid0, r_valid1}, 2'b01);
        check("r_info1", r_info1, exp);
        check("ar_busy", {ar_ready0, ar_ready1}, 2'b00);
        step();
        check("r_lat2", {r_valid0, r_valid1}, 2'b11);
        check("r_info0", r_info0, exp);
        check("r_hold1", r_info1, exp);
        for (int h = 0; h < hold; h++) begin
            step();
            check("r_stall_v", {r_valid0, r_valid1, ar_ready0, ar_ready1}, 4'b1100);
            check("r_stall0", r_info0, exp);
            check("r_stall1", r_info1, exp);
        end
        obs = r_info0[63:0];
        r_ready = 1'b1;
        step();
        r_ready = 1'b0;
        check("r_done", {r_valid0, r_valid1, ar_ready0, ar_ready1}, 4'b0011);
        $display("[TB] read  id=%0d addr=%h data=%h", id, addr, obs);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] rd;
        logic [63:0] old_word;
        logic [31:0] a;

        rst = 1'b1;
        aw_valid = 0; w_valid = 0; b_ready = 0; ar_valid = 0; r_ready = 0;
        aw_info = '0; w_info = '0; ar_info = '0;
        step(); step();
        check("rst_ready", {aw_ready0, w_ready0, ar_ready0, aw_ready1, w_ready1, ar_ready1}, 6'b0);
        check("rst_valid", {b_valid0, r_valid0, b_valid1, r_valid1}, 4'b0);
        check("rst_binfo", {b_info0, b_info1}, 12'h0);
        check("rst_rinfo0", r_info0, 70'h0);
        check("rst_rinfo1", r_info1, 70'h0);
        rst = 1'b0;
        step();
        check("post_rst_ready", {aw_ready0, w_ready0, ar_ready0, aw_ready1, w_ready1, ar_ready1}, 6'b111111);

        // Give every word a defined value in both DUTs and in the model
        for (int i = 0; i < MEM_WORDS; i++) begin
            do_write(4'($urandom), 32'(i * 8), 8'hFF, {$urandom, $urandom});
        end

        // Basic write then read
        do_write(4'd3, 32'h10, 8'hFF, 64'h1122334455667788);
        do_read(4'd5, 32'h10, 0, rd);
        check("basic_rdata", rd, 64'h1122334455667788);

        // W arrives three cycles ahead of AW
        do_write(4'd0, 32'h20, 8'hFF, 64'hFFFFFFFFFFFFFFFF);
        w_valid = 1'b1; w_info = {8'h0F, 64'hAAAAAAAAAAAAAAAA};
        check("w_first_ready", {w_ready0, w_ready1}, 2'b11);
        step();
        w_valid = 1'b0;
        for (int c = 0; c < 2; c++) begin
            check("w_held", {w_ready0, w_ready1, b_valid0, b_valid1}, 4'b0000);
            step();
        end
        aw_valid = 1'b1; aw_info = {4'd7, 32'h20};
        check("aw_late_ready", {aw_ready0, aw_ready1, w_ready0, w_ready1}, 4'b1100);
        step();
        aw_valid = 1'b0;
        check("w_till_commit", {w_ready0, w_ready1, b_valid0, b_valid1}, 4'b0000);
        step();
        check("late_b", {b_valid0, b_valid1, w_ready0, w_ready1}, 4'b1111);
        check("late_binfo", {b_info0, b_info1}, {4'd7, 2'b00, 4'd7, 2'b00});
        model_write(32'h20, 8'h0F, 64'hAAAAAAAAAAAAAAAA);
        b_ready = 1'b1; step(); b_ready = 1'b0;
        do_read(4'd1, 32'h20, 0, rd);
        check("strb_rdata", rd, 64'hFFFFFFFFAAAAAAAA);

        // B backpressure while a second pair queues behind it
        aw_valid = 1'b1; aw_info = {4'd1, 32'h30};
        w_valid  = 1'b1; w_info  = {8'hFF, 64'h0101010101010101};
        step();
        aw_valid = 1'b0; w_valid = 1'b0;
        step();
        check("stall_b_first", {b_valid0, b_valid1}, 2'b11);
        aw_valid = 1'b1; aw_info = {4'd2, 32'h38};
        w_valid  = 1'b1; w_info  = {8'hFF, 64'h0202020202020202};
        check("stall_pair2_ready", {aw_ready0, w_ready0, aw_ready1, w_ready1}, 4'b1111);
        for (int c = 0; c < 5; c++) begin
            check("stall_binfo", {b_valid0, b_info0, b_valid1, b_info1}, {1'b1, 4'd1, 2'b00, 1'b1, 4'd1, 2'b00});
            step();
            aw_valid = 1'b0; w_valid = 1'b0;
            check("stall_held", {aw_ready0, w_ready0, aw_ready1, w_ready1}, 4'b0000);
        end
        b_ready = 1'b1; step(); b_ready = 1'b0;
        check("stall_gap", {b_valid0, b_valid1}, 2'b00);
        step();
        check("stall_b_second", {b_valid0, b_info0, b_valid1, b_info1}, {1'b1, 4'd2, 2'b00, 1'b1, 4'd2, 2'b00});
        model_write(32'h30, 8'hFF, 64'h0101010101010101);
        model_write(32'h38, 8'hFF, 64'h0202020202020202);
        b_ready = 1'b1; step(); b_ready = 1'b0;
        $display("[TB] stalled B pair completed in order");
        do_read(4'd2, 32'h30, 0, rd);
        check("stall_rd_a", rd, 64'h0101010101010101);

        // Out-of-range accesses
        do_read(4'd9, 32'h800, 0, rd);
        check("oor_resp", {r_info0[65:64], rd}, {2'b11, 64'h0});
        do_write(4'd4, 32'h800, 8'hFF, 64'hDEADBEEFDEADBEEF);
        do_write(4'd8, 32'hFFF8, 8'hFF, 64'h0BADF00D0BADF00D);

        // Long R stall on both latencies
        do_read(4'd6, 32'h10, 4, rd);

        // Write commit and R load collide on one word
        a = 32'h40;
        old_word = model_rdata(a);
        aw_valid = 1'b1; aw_info = {4'd10, a};
        w_valid  = 1'b1; w_info  = {8'hFF, 64'h5A5A5A5A5A5A5A5A};
        ar_valid = 1'b1; ar_info = {4'd11, a};
        step();
        aw_valid = 1'b0; w_valid = 1'b0; ar_valid = 1'b0;
        step();
        check("coll_b", {b_valid0, b_valid1, r_valid0, r_valid1}, 4'b1111);
        check("coll_r0", r_info0, {4'd11, 2'b00, old_word});
        check("coll_r1", r_info1, {4'd11, 2'b00, old_word});
        model_write(a, 8'hFF, 64'h5A5A5A5A5A5A5A5A);
        b_ready = 1'b1; r_ready = 1'b1; step(); b_ready = 1'b0; r_ready = 1'b0;
        $display("[TB] collision read returned %h", old_word);
        do_read(4'd12, a, 0, rd);
        check("coll_after", rd, 64'h5A5A5A5A5A5A5A5A);

        // Randomised traffic
        for (int i = 0; i < 40; i++) begin
            do_write(4'($urandom), $urandom_range(0, 32'hFFF), 8'($urandom), {$urandom, $urandom});
            do_read(4'($urandom), $urandom_range(0, 32'hFFF), $urandom_range(0, 2), rd);
        end

        // Reset with a read in WAIT and an AW held
        ar_valid = 1'b1; ar_info = {4'd11, 32'h48};
        aw_valid = 1'b1; aw_info = {4'd12, 32'h50};
        step();
        ar_valid = 1'b0; aw_valid = 1'b0;
        check("mid_aw_held", {aw_ready0, aw_ready1, ar_ready0}, 3'b000);
        rst = 1'b1;
        step();
        check("mid_rst_valid", {b_valid0, r_valid0, b_valid1, r_valid1}, 4'b0);
        check("mid_rst_ready", {aw_ready0, w_ready0, ar_ready0, aw_ready1, w_ready1, ar_ready1}, 6'b0);
        rst = 1'b0;
        step();
        check("mid_post_ready", {aw_ready0, w_ready0, ar_ready0, aw_ready1, w_ready1, ar_ready1}, 6'b111111);
        for (int c = 0; c < 4; c++) begin
            check("mid_no_resp", {b_valid0, r_valid0, b_valid1, r_valid1}, 4'b0);
            step();
        end
        $display("[TB] mid-operation reset discarded held requests");
        do_write(4'd13, 32'h58, 8'hF0, 64'h123456789ABCDEF0);
        do_read(4'd14, 32'h58, 1, rd);

        // Full memory sweep against the model
        for (int i = 0; i < MEM_WORDS; i++) begin
            do_read(4'(i), 32'(i * 8), 0, rd);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
